// File: rtl/decrypt_pkg.sv
// Shared types and constants for the decrypt sequencer: FSM state encoding,
// the six LFSR tap masks, the default plaintext preamble symbol and a debug view.
package decrypt_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_TRAIN,
    S_DETECT,
    S_RUN,
    S_DONE,
    S_ERR
  } state_e;

  localparam int unsigned N_LFSR = 6;

  // Tap masks of LFSRs 0..5, LFSR i in bits [6i+5:6i].
  localparam logic [5:0] TAP_0 = 6'h21;
  localparam logic [5:0] TAP_1 = 6'h2D;
  localparam logic [5:0] TAP_2 = 6'h30;
  localparam logic [5:0] TAP_3 = 6'h33;
  localparam logic [5:0] TAP_4 = 6'h36;
  localparam logic [5:0] TAP_5 = 6'h39;
  localparam logic [35:0] TAPS = {TAP_5, TAP_4, TAP_3, TAP_2, TAP_1, TAP_0};

  localparam logic [5:0] PAD_DEFAULT = 6'h1F;

  typedef struct packed {
    state_e     state;
    logic [5:0] match;
    logic       one_hot;
  } dbg_t;

endpackage

// File: rtl/decrypt_seq_match_enc.sv
// Reduces the six per-LFSR match flags to an index (highest set bit wins)
// and a flag telling whether exactly one LFSR matched.
module match_enc
  import decrypt_pkg::*;
(
  input  logic [N_LFSR-1:0] match_i,
  output logic [2:0]        idx_o,
  output logic              one_hot_o
);

  always_comb begin
    idx_o = 3'd0;
    for (int i = 0; i < int'(N_LFSR); i++) begin
      if (match_i[i]) idx_o = 3'(i);
    end
  end

  // Non-zero with no second bit set: clearing the lowest set bit leaves zero.
  assign one_hot_o = (match_i != '0) && ((match_i & (match_i - 1'b1)) == '0);

endmodule

// File: rtl/decrypt_seq.sv
// Stream-cipher decrypt sequencer: seeds six external LFSRs from the encrypted
// preamble, identifies the generating LFSR, then decrypts the payload into memory.
// Optional DECRYPT_ERR_EN: zero or multiple LFSR matches end the pass in ERR.
module decrypt_seq
  import decrypt_pkg::*;
#(
  parameter int unsigned RD_BASE  = 64,
  parameter int unsigned WR_BASE  = 0,
  parameter int unsigned MSG_LEN  = 64,
  parameter int unsigned PREAMBLE = 7,
  parameter logic [5:0]  PAD      = PAD_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [2:0]  tap_sel,
  output logic [7:0]  raddr,
  input  logic [7:0]  data_out,
  output logic [7:0]  waddr,
  output logic        wr_en,
  output logic [7:0]  data_in,
  output logic        lfsr_load,
  output logic        lfsr_en,
  output logic [5:0]  lfsr_start,
  input  logic [35:0] lfsr_state,
  output dbg_t        dbg_o
);

  localparam logic [7:0] RD_BASE_B  = 8'(RD_BASE);
  localparam logic [7:0] WR_BASE_B  = 8'(WR_BASE);
  localparam logic [7:0] DET_ADDR   = 8'(RD_BASE + PREAMBLE - 1);
  localparam logic [7:0] RUN_ADDR0  = 8'(RD_BASE + PREAMBLE);
  localparam logic [7:0] TRAIN_LAST = 8'(PREAMBLE - 2);
  localparam logic [7:0] RUN_LAST   = 8'(MSG_LEN - PREAMBLE - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [5:0]  match_q, match_d;
  logic        one_hot_q, one_hot_d;
  logic [2:0]  tap_sel_q, tap_sel_d;
  logic [7:0]  raddr_q, waddr_q, data_in_q;
  logic [5:0]  key;
  logic [5:0]  match_now;
  logic [2:0]  enc_idx;
  logic        enc_one_hot;
  logic [5:0]  sel_state;

  // Memory data XOR PAD is the keystream symbol of the byte being read.
  assign key        = data_out[5:0] ^ PAD;
  assign lfsr_start = key;

  always_comb begin
    for (int i = 0; i < int'(N_LFSR); i++) begin
      match_now[i] = (lfsr_state[6*i +: 6] == key);
    end
  end

  match_enc u_match_enc (
    .match_i   (match_now),
    .idx_o     (enc_idx),
    .one_hot_o (enc_one_hot)
  );

  always_comb begin
    case (tap_sel_q)
      3'd1:    sel_state = lfsr_state[11:6];
      3'd2:    sel_state = lfsr_state[17:12];
      3'd3:    sel_state = lfsr_state[23:18];
      3'd4:    sel_state = lfsr_state[29:24];
      3'd5:    sel_state = lfsr_state[35:30];
      default: sel_state = lfsr_state[5:0];
    endcase
  end

  // start is a one-cycle request honoured only in IDLE, DONE or ERR; pulses
  // arriving while busy are dropped. Idle states hold the last bus values.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    match_d   = match_q;
    one_hot_d = one_hot_q;
    tap_sel_d = tap_sel_q;
    raddr     = raddr_q;
    waddr     = waddr_q;
    data_in   = data_in_q;
    wr_en     = 1'b0;
    lfsr_load = 1'b0;
    lfsr_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        raddr     = RD_BASE_B;
        lfsr_load = 1'b1;
        cnt_d     = 8'd0;
        state_d   = S_TRAIN;
      end
      S_TRAIN: begin
        raddr   = RD_BASE_B + cnt_q;
        lfsr_en = 1'b1;
        if (cnt_q == TRAIN_LAST) begin
          cnt_d   = 8'd0;
          state_d = S_DETECT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DETECT: begin
        raddr     = DET_ADDR;
        lfsr_en   = 1'b1;
        match_d   = match_now;
        one_hot_d = enc_one_hot;
        tap_sel_d = enc_idx;
`ifdef DECRYPT_ERR_EN
        state_d   = enc_one_hot ? S_RUN : S_ERR;
`else
        state_d   = S_RUN;
`endif
      end
      S_RUN: begin
        raddr   = RUN_ADDR0 + cnt_q;
        waddr   = WR_BASE_B + cnt_q;
        wr_en   = 1'b1;
        lfsr_en = 1'b1;
        data_in = data_out ^ {2'b00, sel_state};
        if (cnt_q == RUN_LAST) begin
          cnt_d   = 8'd0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE, S_ERR: begin
        if (start) state_d = S_LOAD;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 8'd0;
      match_q   <= 6'd0;
      one_hot_q <= 1'b0;
      tap_sel_q <= 3'd0;
      raddr_q   <= 8'd0;
      waddr_q   <= 8'd0;
      data_in_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      match_q   <= match_d;
      one_hot_q <= one_hot_d;
      tap_sel_q <= tap_sel_d;
      raddr_q   <= raddr;
      waddr_q   <= waddr;
      data_in_q <= data_in;
    end
  end

  assign busy    = (state_q == S_LOAD) || (state_q == S_TRAIN) ||
                   (state_q == S_DETECT) || (state_q == S_RUN);
  assign done    = (state_q == S_DONE);
  assign tap_sel = tap_sel_q;
`ifdef DECRYPT_ERR_EN
  assign err     = (state_q == S_ERR);
`else
  assign err     = 1'b0;
`endif

  assign dbg_o = '{state: state_q, match: match_q, one_hot: one_hot_q};

endmodule

// File: tb/tb_decrypt_seq.sv
// Directed bench for decrypt_seq: memory and LFSR models, hand-chosen keys,
// one task per scenario with inline checks and a single summary line.
module tb_decrypt_seq;
  import decrypt_pkg::*;

  localparam int P   = 7;
  localparam int M   = 64;
  localparam int RB  = 64;
  localparam int WB  = 0;
  localparam int M2  = 16;
  localparam int RB2 = 250;
  localparam int WB2 = 100;
  localparam logic [5:0] PADV = 6'h1F;

  logic [5:0] tap_tab [6] = '{6'h21, 6'h2D, 6'h30, 6'h33, 6'h36, 6'h39};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start, busy, done, err, wr_en, lfsr_load, lfsr_en;
  logic [2:0]  tap_sel;
  logic [7:0]  raddr, data_out, waddr, data_in;
  logic [5:0]  lfsr_start;
  logic [35:0] lfsr_state;
  dbg_t        dbg;

  logic        start2, busy2, done2, err2, wr_en2, lfsr_load2, lfsr_en2;
  logic [2:0]  tap_sel2;
  logic [7:0]  raddr2, data_out2, waddr2, data_in2;
  logic [5:0]  lfsr_start2;
  logic [35:0] lfsr_state2;
  dbg_t        dbg2;

  logic [7:0] mem  [256];
  logic [7:0] mem2 [256];
  logic [5:0] lf  [6];
  logic [5:0] lf2 [6];
  int wr_cnt = 0, wr_cnt2 = 0, load_cnt = 0;
  int n_cmp = 0, n_bad = 0;

  decrypt_seq u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .err(err),
    .tap_sel(tap_sel), .raddr(raddr), .data_out(data_out), .waddr(waddr),
    .wr_en(wr_en), .data_in(data_in), .lfsr_load(lfsr_load), .lfsr_en(lfsr_en),
    .lfsr_start(lfsr_start), .lfsr_state(lfsr_state), .dbg_o(dbg)
  );

  decrypt_seq #(.RD_BASE(RB2), .WR_BASE(WB2), .MSG_LEN(M2)) u_dut_wrap (
    .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2), .err(err2),
    .tap_sel(tap_sel2), .raddr(raddr2), .data_out(data_out2), .waddr(waddr2),
    .wr_en(wr_en2), .data_in(data_in2), .lfsr_load(lfsr_load2), .lfsr_en(lfsr_en2),
    .lfsr_start(lfsr_start2), .lfsr_state(lfsr_state2), .dbg_o(dbg2)
  );

  function automatic logic [5:0] lfsr_step(input logic [5:0] s, input logic [5:0] t);
    return {s[4:0], ^(s & t)};
  endfunction

  function automatic logic [7:0] plain_byte(input int k);
    return 8'(k * 29 + 65);
  endfunction

  assign data_out    = mem[raddr];
  assign data_out2   = mem2[raddr2];
  assign lfsr_state  = {lf[5], lf[4], lf[3], lf[2], lf[1], lf[0]};
  assign lfsr_state2 = {lf2[5], lf2[4], lf2[3], lf2[2], lf2[1], lf2[0]};

  always @(posedge clk) begin
    if (wr_en) begin
      mem[waddr] <= data_in;
      wr_cnt <= wr_cnt + 1;
    end
    if (lfsr_load) load_cnt <= load_cnt + 1;
    for (int i = 0; i < 6; i++) begin
      if (lfsr_load) lf[i] <= lfsr_start;
      else if (lfsr_en) lf[i] <= lfsr_step(lf[i], tap_tab[i]);
    end
  end

  always @(posedge clk) begin
    if (wr_en2) begin
      mem2[waddr2] <= data_in2;
      wr_cnt2 <= wr_cnt2 + 1;
    end
    for (int i = 0; i < 6; i++) begin
      if (lfsr_load2) lf2[i] <= lfsr_start2;
      else if (lfsr_en2) lf2[i] <= lfsr_step(lf2[i], tap_tab[i]);
    end
  end

  // Encrypt PAD preamble + payload with LFSR 'tap' from 'seed'; fill write area with EE.
  task automatic load_msg(input int which, input int tap, input logic [5:0] seed,
                          input int rb, input int wb, input int mlen, input int corrupt);
    logic [5:0] ks;
    logic [7:0] pt, ct;
    ks = seed;
    for (int n = 0; n < mlen; n++) begin
      pt = (n < P) ? {2'b00, PADV} : plain_byte(n - P);
      ct = pt ^ {2'b00, ks};
      if (n == corrupt) ct = ct ^ 8'h3F;
      if (which == 0) mem[8'(rb + n)] = ct;
      else mem2[8'(rb + n)] = ct;
      ks = lfsr_step(ks, tap_tab[tap]);
    end
    for (int k = 0; k < mlen - P + 4; k++) begin
      if (which == 0) mem[8'(wb + k)] = 8'hEE;
      else mem2[8'(wb + k)] = 8'hEE;
    end
  endtask

  // Called #1 after a rising edge; returns edges until done/err, or -1 on timeout.
  task automatic run_pass(input int inject, output int lat);
    lat = -1;
    start = 1'b1;
    for (int n = 1; n <= 300; n++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (inject != 0 && (n == 3 || n == 20)) start = 1'b1;
      if (done || err) begin
        lat = n;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    start2 = 1'b0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'h00;
      mem2[i] = 8'h00;
    end
    for (int i = 0; i < 6; i++) begin
      lf[i] = 6'h00;
      lf2[i] = 6'h00;
    end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, done, err, wr_en, lfsr_load, lfsr_en} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_strobes: got %b want 000000", {busy, done, err, wr_en, lfsr_load, lfsr_en});
    end
    n_cmp++;
    if ({raddr, waddr, data_in, tap_sel} !== 27'd0) begin
      n_bad++;
      $display("FAIL reset_buses: raddr %h waddr %h data_in %h tap_sel %0d want all 0", raddr, waddr, data_in, tap_sel);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (dbg.state !== S_IDLE || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle: state %0d busy %b want IDLE 0", dbg.state, busy);
    end
  endtask

  task automatic test_tap(input int t, input int inject);
    int lat, w0, l0, bad, first;
    load_msg(0, t, 6'h0A, RB, WB, M, -1);
    w0 = wr_cnt;
    l0 = load_cnt;
    run_pass(inject, lat);
    n_cmp++;
    if (lat !== 66) begin
      n_bad++;
      $display("FAIL latency_tap%0d: got %0d want 66", t, lat);
    end
    n_cmp++;
    if (tap_sel !== 3'(t) || done !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL select_tap%0d: tap_sel %0d done %b busy %b want %0d 1 0", t, tap_sel, done, busy, t);
    end
    n_cmp++;
    if (wr_cnt - w0 !== 57 || load_cnt - l0 !== 1) begin
      n_bad++;
      $display("FAIL counts_tap%0d: writes %0d loads %0d want 57 1", t, wr_cnt - w0, load_cnt - l0);
    end
    bad = 0;
    first = 0;
    for (int k = 0; k < 57; k++) begin
      if (mem[8'(WB + k)] !== plain_byte(k)) begin
        if (bad == 0) first = k;
        bad++;
      end
    end
    n_cmp++;
    if (bad != 0 || mem[8'(WB + 57)] !== 8'hEE) begin
      n_bad++;
      $display("FAIL mem_tap%0d: %0d wrong, first %0d got %h want %h, guard %h want ee",
               t, bad, first, mem[8'(WB + first)], plain_byte(first), mem[8'(WB + 57)]);
    end
  endtask

  task automatic test_done_hold;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (done !== 1'b1 || wr_en !== 1'b0 || lfsr_en !== 1'b0 || lfsr_load !== 1'b0) begin
      n_bad++;
      $display("FAIL done_hold: done %b wr_en %b lfsr_en %b lfsr_load %b want 1 0 0 0", done, wr_en, lfsr_en, lfsr_load);
    end
    n_cmp++;
    if (raddr !== 8'd127 || waddr !== 8'd56 || data_in !== plain_byte(56)) begin
      n_bad++;
      $display("FAIL done_buses: raddr %h waddr %h data_in %h want 7f 38 %h", raddr, waddr, data_in, plain_byte(56));
    end
  endtask

  task automatic test_restart;
    test_tap(3, 1);
    test_tap(3, 0);
  endtask

  task automatic test_corrupt;
    int lat, w0;
    load_msg(0, 1, 6'h0A, RB, WB, M, 6);
    w0 = wr_cnt;
    run_pass(0, lat);
`ifdef DECRYPT_ERR_EN
    n_cmp++;
    if (lat !== 9 || err !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL corrupt_err: lat %0d err %b done %b busy %b want 9 1 0 0", lat, err, done, busy);
    end
    n_cmp++;
    if (wr_cnt - w0 !== 0) begin
      n_bad++;
      $display("FAIL corrupt_writes: got %0d want 0", wr_cnt - w0);
    end
`else
    n_cmp++;
    if (lat !== 66 || err !== 1'b0 || done !== 1'b1 || tap_sel !== 3'd0) begin
      n_bad++;
      $display("FAIL corrupt_nomatch: lat %0d err %b done %b tap_sel %0d want 66 0 1 0", lat, err, done, tap_sel);
    end
    n_cmp++;
    if (wr_cnt - w0 !== 57) begin
      n_bad++;
      $display("FAIL corrupt_writes: got %0d want 57", wr_cnt - w0);
    end
`endif
  endtask

  task automatic test_reset_mid;
    int w0;
    load_msg(0, 2, 6'h0A, RB, WB, M, -1);
    w0 = wr_cnt;
    start = 1'b1;
    for (int n = 1; n <= 19; n++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, err, wr_en, lfsr_load, lfsr_en} !== 6'b0 || dbg.state !== S_IDLE) begin
      n_bad++;
      $display("FAIL midreset_strobes: got %b state %0d want 000000 IDLE",
               {busy, done, err, wr_en, lfsr_load, lfsr_en}, dbg.state);
    end
    n_cmp++;
    if ({raddr, waddr, data_in, tap_sel} !== 27'd0 || dbg.match !== 6'd0) begin
      n_bad++;
      $display("FAIL midreset_buses: raddr %h waddr %h data_in %h tap_sel %0d match %b want 0",
               raddr, waddr, data_in, tap_sel, dbg.match);
    end
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (wr_cnt - w0 !== 10) begin
      n_bad++;
      $display("FAIL midreset_writes: got %0d want 10", wr_cnt - w0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_wrap;
    int lat, w0, bad;
    logic [7:0] ra7, ra8;
    load_msg(1, 4, 6'h0A, RB2, WB2, M2, -1);
    w0 = wr_cnt2;
    lat = -1;
    ra7 = 8'h00;
    ra8 = 8'hFF;
    start2 = 1'b1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      start2 = 1'b0;
      if (n == 7) ra7 = raddr2;
      if (n == 8) ra8 = raddr2;
      if (done2 || err2) begin
        lat = n;
        break;
      end
    end
    start2 = 1'b0;
    n_cmp++;
    if (ra7 !== 8'hFF || ra8 !== 8'h00) begin
      n_bad++;
      $display("FAIL wrap_raddr: got %h then %h want ff then 00", ra7, ra8);
    end
    n_cmp++;
    if (lat !== 18 || tap_sel2 !== 3'd4 || wr_cnt2 - w0 !== 9) begin
      n_bad++;
      $display("FAIL wrap_pass: lat %0d tap_sel %0d writes %0d want 18 4 9", lat, tap_sel2, wr_cnt2 - w0);
    end
    bad = 0;
    for (int k = 0; k < 9; k++) begin
      if (mem2[8'(WB2 + k)] !== plain_byte(k)) bad++;
    end
    n_cmp++;
    if (bad != 0 || mem2[8'(WB2 + 9)] !== 8'hEE) begin
      n_bad++;
      $display("FAIL wrap_mem: %0d bytes wrong, guard %h want 0 ee", bad, mem2[8'(WB2 + 9)]);
    end
  endtask

  initial begin
    test_reset;
    test_tap(1, 0);
    test_done_hold;
    for (int t = 0; t < 6; t++) begin
      if (t != 1) test_tap(t, 0);
    end
    test_restart;
    test_corrupt;
    test_reset_mid;
    test_wrap;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
